vec_lane_array: RTL and testbench
=================================

// Module: vec_lane_array
// PURPOSE
//  Parametrised multi-lane vector execution unit. It is the successor of the single 32-bit
//  element PE: NUM_LANES ELEN-bit lanes, per-lane mask and tail (vl) control, cross-lane
//  element slides, and a 2-stage valid/ready pipeline. It sits between vector operand
//  read and vector register writeback. One beat carries one full lane-group.
// PARAMETERS
//  NUM_LANES  4   lanes per beat (power of 2, >=2)
//  ELEN       32  element width in bits
//  LANE_W     $clog2(NUM_LANES)+1 (localparam) width of vl and offset fields
// PORTS
//  clk        in   1                 clock, rising edge
//  rst        in   1                 synchronous, active-high reset
//  in_valid   in   1                 beat offered
//  in_ready   out  1                 beat accepted when in_valid&&in_ready
//  in_funct6  in   6                 operation
//  in_a       in   NUM_LANES*ELEN    vs2 elements, lane i = [i*ELEN +: ELEN]
//  in_b       in   NUM_LANES*ELEN    vs1 elements
//  in_vd      in   NUM_LANES*ELEN    old vd, used for masked-off/tail lanes
//  in_mask    in   NUM_LANES         per-lane enable (1 = active)
//  in_vm      in   1                 1 = unmasked (ignore in_mask)
//  in_vl      in   LANE_W            active lane count, 0..NUM_LANES
//  in_off     in   LANE_W            slide offset in elements
//  out_valid  out  1                 result beat valid
//  out_ready  in   1                 consumer accepts result
//  out_data   out  NUM_LANES*ELEN    result elements
//  out_we     out  NUM_LANES         per-lane write enable (active && body)
//  out_err    out  1                 illegal funct6 on this beat
// BEHAVIOUR
//  Reset: out_valid=0, out_data=0, out_we=0, out_err=0, both stage valids=0; in_ready=1 the
//   cycle after reset deasserts. Any beat in flight at reset is dropped.
//  Ops (funct6): VADD 000000 a+b; VSUB 000010 a-b; VMINU 000100; VMAXU 000110 (unsigned);
//   VAND 001001; VOR 001010; VXOR 001011; VMV 010111 result=b; VSLIDEUP 001110;
//   VSLIDEDOWN 001111. Arithmetic is modulo 2^ELEN. No carries cross lanes.
//  Lane i is active when i<in_vl and (in_vm || in_mask[i]). Inactive lanes output in_vd[i]
//   with out_we[i]=0. This is mask/tail undisturbed.
//  VSLIDEUP: lane i=a[i-off] if i>=off, else vd[i] and we=0. VSLIDEDOWN: lane i=a[i+off] if
//   i+off<NUM_LANES, else 0. off>=NUM_LANES: slideup writes nothing; slidedown gives all 0.
//  Illegal funct6: active lanes output 0 with we=0, out_err=1. No other side effect.
//  in_vl>NUM_LANES is treated as NUM_LANES.
//  Pipeline: S1 registers the decoded operands and the lane-active vector. S2 registers
//   the computed result, which drives the outputs. Latency is 2 cycles from accept to
//   out_valid. Throughput is 1 beat/cycle while out_ready=1.
//  Handshake: s2_adv = !s2_valid || out_ready; s1_adv = !s1_valid || s2_adv;
//   in_ready = s1_adv. in_ready depends only on state and out_ready, never on in_valid.
//  out_valid held high with stable out_data/out_we/out_err until out_ready. Each beat is
//   accepted and emitted exactly once, in order. No bubbles when continuously ready.
//  Back-pressure: with both stages full and out_ready=0, in_ready=0. Simultaneous
//   out_ready and in_valid in the full state shifts the pipe and accepts in the same cycle.
// TESTING
//  1 Reset: hold rst 3 cycles, then release -> out_valid=0, out_data=0; in_ready=1 next
//    cycle.
//  2 VADD, vm=1, vl=4: a=lanes{1,2,3,0xFFFFFFFF}, b={1,1,1,1} -> out_data={2,3,4,0} after
//    2 cycles; out_we=4'b1111.
//  3 VSUB, vm=0, mask=4'b0101, vl=3: vd={9,9,9,9}, a={5,5,5,5}, b={1,2,3,4} ->
//    {4,9,2,9}; out_we=4'b0101.
//  4 VSLIDEUP off=1, a={10,20,30,40}, vd={7,7,7,7}, vl=4 -> {7,10,20,30}, we=4'b1110;
//    VSLIDEDOWN off=3 -> {40,0,0,0}.
//  5 Back-pressure: stream 6 VXOR beats and hold out_ready=0 for 4 cycles -> in_ready
//    drops after 2 accepts; all 6 results emerge in order once ready, none lost or
//    duplicated.
//  6 funct6=111111 -> out_err=1 and out_we=0, out_data=0 on active lanes. Then assert rst
//    mid-stream -> out_valid=0 next cycle and no stale beat emitted.

Source files
------------

// File: rtl/vec_lane_array.sv
// Multi-lane vector execution unit: per-lane mask/tail control, cross-lane slides and a
// 2-stage valid/ready pipeline (S1 = decoded operands, S2 = result driving the outputs).
module vec_lane_array #(
   parameter int NUM_LANES = 4,
   parameter int ELEN      = 32,
   localparam int LANE_W   = $clog2(NUM_LANES) + 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [5:0]                in_funct6,
   input  logic [NUM_LANES*ELEN-1:0] in_a,
   input  logic [NUM_LANES*ELEN-1:0] in_b,
   input  logic [NUM_LANES*ELEN-1:0] in_vd,
   input  logic [NUM_LANES-1:0]      in_mask,
   input  logic                      in_vm,
   input  logic [LANE_W-1:0]         in_vl,
   input  logic [LANE_W-1:0]         in_off,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [NUM_LANES*ELEN-1:0] out_data,
   output logic [NUM_LANES-1:0]      out_we,
   output logic                      out_err
);

   localparam logic [5:0] F_VADD       = 6'b000000;
   localparam logic [5:0] F_VSUB       = 6'b000010;
   localparam logic [5:0] F_VMINU      = 6'b000100;
   localparam logic [5:0] F_VMAXU      = 6'b000110;
   localparam logic [5:0] F_VAND       = 6'b001001;
   localparam logic [5:0] F_VOR        = 6'b001010;
   localparam logic [5:0] F_VXOR       = 6'b001011;
   localparam logic [5:0] F_VMV        = 6'b010111;
   localparam logic [5:0] F_VSLIDEUP   = 6'b001110;
   localparam logic [5:0] F_VSLIDEDOWN = 6'b001111;

   localparam int                 VW     = NUM_LANES * ELEN;
   localparam logic [LANE_W-1:0] VL_MAX = LANE_W'(NUM_LANES);

   typedef logic [ELEN-1:0] elem_t;

   // Handshake: a stage may load when it is empty or its contents move on this cycle.
   // in_ready is a function of pipeline state and out_ready only, never of in_valid.
   logic s1_adv, s2_adv;

   logic                  s1_valid_q;
   logic [5:0]            s1_op_q;
   logic [VW-1:0]         s1_a_q, s1_b_q, s1_vd_q;
   logic [NUM_LANES-1:0]  s1_act_q;
   logic [LANE_W-1:0]     s1_off_q;
   logic                  s1_err_q;

   logic                  s2_valid_q;
   logic [VW-1:0]         s2_data_q;
   logic [NUM_LANES-1:0]  s2_we_q;
   logic                  s2_err_q;

   logic [LANE_W-1:0]     vl_eff;
   logic [NUM_LANES-1:0]  act_d;
   logic                  err_d;
   logic [VW-1:0]         res_d;
   logic [NUM_LANES-1:0]  we_d;
   elem_t                 a_e, b_e, vd_e, r_e;
   logic                  w_e;

   assign s2_adv   = !s2_valid_q || out_ready;
   assign s1_adv   = !s1_valid_q || s2_adv;
   assign in_ready = s1_adv;

   // Decode: clamp vl, build the lane-active vector and flag unknown opcodes.
   always_comb begin
      vl_eff = (in_vl > VL_MAX) ? VL_MAX : in_vl;
      act_d  = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         act_d[i] = (LANE_W'(i) < vl_eff) && (in_vm || in_mask[i]);
      end
      case (in_funct6)
         F_VADD, F_VSUB, F_VMINU, F_VMAXU, F_VAND, F_VOR, F_VXOR,
         F_VMV, F_VSLIDEUP, F_VSLIDEDOWN: err_d = 1'b0;
         default:                         err_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_op_q    <= '0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_vd_q    <= '0;
         s1_act_q   <= '0;
         s1_off_q   <= '0;
         s1_err_q   <= 1'b0;
      end else if (s1_adv) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_op_q  <= in_funct6;
            s1_a_q   <= in_a;
            s1_b_q   <= in_b;
            s1_vd_q  <= in_vd;
            s1_act_q <= act_d;
            s1_off_q <= in_off;
            s1_err_q <= err_d;
         end
      end
   end

   // Execute: inactive lanes keep old vd with we=0; slides pick source lanes by offset.
   always_comb begin
      res_d = s1_vd_q;
      we_d  = '0;
      a_e   = '0;
      b_e   = '0;
      vd_e  = '0;
      r_e   = '0;
      w_e   = 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
         a_e  = s1_a_q[i*ELEN +: ELEN];
         b_e  = s1_b_q[i*ELEN +: ELEN];
         vd_e = s1_vd_q[i*ELEN +: ELEN];
         r_e  = '0;
         w_e  = 1'b1;
         case (s1_op_q)
            F_VADD:  r_e = a_e + b_e;
            F_VSUB:  r_e = a_e - b_e;
            F_VMINU: r_e = (a_e < b_e) ? a_e : b_e;
            F_VMAXU: r_e = (a_e > b_e) ? a_e : b_e;
            F_VAND:  r_e = a_e & b_e;
            F_VOR:   r_e = a_e | b_e;
            F_VXOR:  r_e = a_e ^ b_e;
            F_VMV:   r_e = b_e;
            F_VSLIDEUP: begin
               if (i >= int'(s1_off_q)) begin
                  for (int j = 0; j < NUM_LANES; j++) begin
                     if (j + int'(s1_off_q) == i) r_e = s1_a_q[j*ELEN +: ELEN];
                  end
               end else begin
                  r_e = vd_e;
                  w_e = 1'b0;
               end
            end
            F_VSLIDEDOWN: begin
               for (int j = 0; j < NUM_LANES; j++) begin
                  if (i + int'(s1_off_q) == j) r_e = s1_a_q[j*ELEN +: ELEN];
               end
            end
            default: begin
               r_e = '0;
               w_e = 1'b0;
            end
         endcase
         if (s1_act_q[i]) begin
            res_d[i*ELEN +: ELEN] = r_e;
            we_d[i]               = w_e;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_we_q    <= '0;
         s2_err_q   <= 1'b0;
      end else if (s2_adv) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_data_q <= res_d;
            s2_we_q   <= we_d;
            s2_err_q  <= s1_err_q;
         end
      end
   end

   assign out_valid = s2_valid_q;
   assign out_data  = s2_data_q;
   assign out_we    = s2_we_q;
   assign out_err   = s2_err_q;

endmodule

// File: tb/tb_vec_lane_array.sv
// Bench for vec_lane_array: table of single-beat vectors with hand-computed results,
// followed by back-pressure streaming and reset-in-flight sequences.
module tb_vec_lane_array;

   localparam int N  = 4;
   localparam int E  = 32;
   localparam int LW = 3;
   localparam int W  = N * E;
   localparam int NV = 15;

   localparam logic [5:0] F_VADD       = 6'b000000;
   localparam logic [5:0] F_VSUB       = 6'b000010;
   localparam logic [5:0] F_VMINU      = 6'b000100;
   localparam logic [5:0] F_VMAXU      = 6'b000110;
   localparam logic [5:0] F_VAND       = 6'b001001;
   localparam logic [5:0] F_VOR        = 6'b001010;
   localparam logic [5:0] F_VXOR       = 6'b001011;
   localparam logic [5:0] F_VMV        = 6'b010111;
   localparam logic [5:0] F_VSLIDEUP   = 6'b001110;
   localparam logic [5:0] F_VSLIDEDOWN = 6'b001111;
   localparam logic [5:0] F_ILLEGAL    = 6'b111111;

   // clock / reset
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          in_valid, in_ready, in_vm, out_valid, out_ready, out_err;
   logic [5:0]    in_funct6;
   logic [W-1:0]  in_a, in_b, in_vd, out_data;
   logic [N-1:0]  in_mask, out_we;
   logic [LW-1:0] in_vl, in_off;

   vec_lane_array #(.NUM_LANES(N), .ELEN(E)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_funct6(in_funct6),
      .in_a(in_a), .in_b(in_b), .in_vd(in_vd), .in_mask(in_mask), .in_vm(in_vm),
      .in_vl(in_vl), .in_off(in_off),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_we(out_we), .out_err(out_err)
   );

   typedef struct packed {
      logic [5:0]    f;
      logic          vm;
      logic [N-1:0]  mask;
      logic [LW-1:0] vl;
      logic [LW-1:0] off;
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [W-1:0]  vd;
      logic [W-1:0]  exp_d;
      logic [N-1:0]  exp_we;
      logic          exp_err;
   } vec_t;

   vec_t         vecs [NV];
   logic [W-1:0] exp_q [$];
   int           n_pass  = 0;
   int           n_total = 0;

   function automatic logic [W-1:0] lanes(input logic [E-1:0] l0, input logic [E-1:0] l1,
                                          input logic [E-1:0] l2, input logic [E-1:0] l3);
      return {l3, l2, l1, l0};
   endfunction

   function automatic vec_t mk(input logic [5:0] f, input logic vm, input logic [N-1:0] mask,
                               input logic [LW-1:0] vl, input logic [LW-1:0] off,
                               input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] vd, input logic [W-1:0] exp_d,
                               input logic [N-1:0] exp_we, input logic exp_err);
      vec_t v;
      v.f = f; v.vm = vm; v.mask = mask; v.vl = vl; v.off = off;
      v.a = a; v.b = b; v.vd = vd;
      v.exp_d = exp_d; v.exp_we = exp_we; v.exp_err = exp_err;
      return v;
   endfunction

   // scoreboard compare
   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // driver: one beat through an otherwise empty pipe, then check the result
   task automatic run_vec(input int k);
      vec_t v;
      v = vecs[k];
      @(negedge clk);
      in_funct6 = v.f;  in_vm = v.vm;  in_mask = v.mask;
      in_vl     = v.vl; in_off = v.off;
      in_a      = v.a;  in_b = v.b;    in_vd = v.vd;
      in_valid  = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_not_yet_valid", k), W'(out_valid), W'(0));
      @(negedge clk);
      chk($sformatf("v%0d_valid", k), W'(out_valid), W'(1));
      chk($sformatf("v%0d_data", k), out_data, v.exp_d);
      chk($sformatf("v%0d_we", k), W'(out_we), W'(v.exp_we));
      chk($sformatf("v%0d_err", k), W'(out_err), W'(v.exp_err));
   endtask

   initial begin
      logic [W-1:0] a1, v7, xb;
      int sent, rcvd, last_pop, stale;

      a1 = lanes(32'd10, 32'd20, 32'd30, 32'd40);
      v7 = lanes(32'd7, 32'd7, 32'd7, 32'd7);
      xb = lanes(32'h0F0F0F0F, 32'h12345678, 32'hFFFFFFFF, 32'h00000000);

      vecs[0]  = mk(F_VADD, 1'b1, 4'b0000, 3'd4, 3'd0,
                    lanes(32'd1, 32'd2, 32'd3, 32'hFFFFFFFF), lanes(32'd1, 32'd1, 32'd1, 32'd1), v7,
                    lanes(32'd2, 32'd3, 32'd4, 32'd0), 4'b1111, 1'b0);
      vecs[1]  = mk(F_VSUB, 1'b0, 4'b0101, 3'd3, 3'd0,
                    lanes(32'd5, 32'd5, 32'd5, 32'd5), lanes(32'd1, 32'd2, 32'd3, 32'd4),
                    lanes(32'd9, 32'd9, 32'd9, 32'd9),
                    lanes(32'd4, 32'd9, 32'd2, 32'd9), 4'b0101, 1'b0);
      vecs[2]  = mk(F_VSLIDEUP, 1'b1, 4'b0000, 3'd4, 3'd1, a1, '0, v7,
                    lanes(32'd7, 32'd10, 32'd20, 32'd30), 4'b1110, 1'b0);
      vecs[3]  = mk(F_VSLIDEDOWN, 1'b1, 4'b0000, 3'd4, 3'd3, a1, '0, v7,
                    lanes(32'd40, 32'd0, 32'd0, 32'd0), 4'b1111, 1'b0);
      vecs[4]  = mk(F_VMINU, 1'b1, 4'b0000, 3'd4, 3'd0,
                    lanes(32'd5, 32'hFFFFFFFF, 32'd0, 32'd7), lanes(32'd3, 32'd1, 32'd0, 32'd8), v7,
                    lanes(32'd3, 32'd1, 32'd0, 32'd7), 4'b1111, 1'b0);
      vecs[5]  = mk(F_VMAXU, 1'b1, 4'b0000, 3'd4, 3'd0,
                    lanes(32'd5, 32'hFFFFFFFF, 32'd0, 32'd7), lanes(32'd3, 32'd1, 32'd0, 32'd8), v7,
                    lanes(32'd5, 32'hFFFFFFFF, 32'd0, 32'd8), 4'b1111, 1'b0);
      vecs[6]  = mk(F_VAND, 1'b1, 4'b0000, 3'd4, 3'd0,
                    lanes(32'hF0F0F0F0, 32'hFFFF0000, 32'h12345678, 32'h0),
                    lanes(32'hFF00FF00, 32'h00FFFF00, 32'hFFFFFFFF, 32'hFFFFFFFF), v7,
                    lanes(32'hF000F000, 32'h00FF0000, 32'h12345678, 32'h0), 4'b1111, 1'b0);
      vecs[7]  = mk(F_VOR, 1'b1, 4'b0000, 3'd4, 3'd0,
                    lanes(32'hF0F0F0F0, 32'hFFFF0000, 32'h12345678, 32'h0),
                    lanes(32'hFF00FF00, 32'h00FFFF00, 32'hFFFFFFFF, 32'hFFFFFFFF), v7,
                    lanes(32'hFFF0FFF0, 32'hFFFFFF00, 32'hFFFFFFFF, 32'hFFFFFFFF), 4'b1111, 1'b0);
      vecs[8]  = mk(F_VXOR, 1'b1, 4'b0000, 3'd4, 3'd0,
                    lanes(32'hF0F0F0F0, 32'hFFFF0000, 32'h12345678, 32'h0),
                    lanes(32'hFF00FF00, 32'h00FFFF00, 32'hFFFFFFFF, 32'hFFFFFFFF), v7,
                    lanes(32'h0FF00FF0, 32'hFF00FF00, 32'hEDCBA987, 32'hFFFFFFFF), 4'b1111, 1'b0);
      vecs[9]  = mk(F_VMV, 1'b1, 4'b0000, 3'd2, 3'd0, a1,
                    lanes(32'd11, 32'd22, 32'd33, 32'd44), v7,
                    lanes(32'd11, 32'd22, 32'd7, 32'd7), 4'b0011, 1'b0);
      vecs[10] = mk(F_VADD, 1'b1, 4'b0000, 3'd7, 3'd0,
                    lanes(32'd1, 32'd1, 32'd1, 32'd1), lanes(32'd2, 32'd2, 32'd2, 32'd2), v7,
                    lanes(32'd3, 32'd3, 32'd3, 32'd3), 4'b1111, 1'b0);
      vecs[11] = mk(F_VADD, 1'b1, 4'b0000, 3'd0, 3'd0, a1, a1, v7, v7, 4'b0000, 1'b0);
      vecs[12] = mk(F_ILLEGAL, 1'b0, 4'b1011, 3'd4, 3'd0, a1, a1, v7,
                    lanes(32'd0, 32'd0, 32'd7, 32'd0), 4'b0000, 1'b1);
      vecs[13] = mk(F_VSLIDEUP, 1'b1, 4'b0000, 3'd4, 3'd4, a1, '0, v7, v7, 4'b0000, 1'b0);
      vecs[14] = mk(F_VSLIDEDOWN, 1'b1, 4'b0000, 3'd4, 3'd5, a1, '0, v7, '0, 4'b1111, 1'b0);

      in_valid = 1'b0; out_ready = 1'b0; in_funct6 = '0; in_a = '0; in_b = '0; in_vd = '0;
      in_mask = '0; in_vm = 1'b0; in_vl = '0; in_off = '0;

      // reset held for three cycles
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", W'(out_valid), W'(0));
      chk("rst_out_data", out_data, W'(0));
      chk("rst_out_we", W'(out_we), W'(0));
      chk("rst_out_err", W'(out_err), W'(0));
      chk("rst_in_ready", W'(in_ready), W'(1));

      for (int k = 0; k < NV; k++) run_vec(k);

      // back-pressure: six XOR beats, consumer stalled for the first four cycles
      sent = 0; rcvd = 0; last_pop = -1;
      for (int c = 0; c < 40 && rcvd < 6; c++) begin
         @(negedge clk);
         out_ready = (c >= 4);
         in_valid  = (sent < 6);
         in_funct6 = F_VXOR; in_vm = 1'b1; in_vl = 3'd4; in_off = 3'd0; in_mask = '0; in_vd = v7;
         in_a = lanes(32'h100 + 32'(sent), 32'h200 + 32'(sent), 32'h300 + 32'(sent),
                      32'h400 + 32'(sent));
         in_b = xb;
         #1;
         if (c == 2 || c == 3) chk($sformatf("bp_in_ready_full_c%0d", c), W'(in_ready), W'(0));
         if (c == 3) begin
            chk("bp_accepts_before_stall", W'(sent), W'(2));
            chk("bp_hold_valid", W'(out_valid), W'(1));
            chk("bp_hold_data", out_data, exp_q[0]);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL bp_unexpected_beat: got %h, expected no beat", out_data);
            end else begin
               chk($sformatf("bp_data_%0d", rcvd), out_data, exp_q.pop_front());
               chk($sformatf("bp_we_%0d", rcvd), W'(out_we), W'(4'b1111));
            end
            rcvd++;
            last_pop = c;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(in_a ^ in_b);
            sent++;
         end
      end
      chk("bp_received", W'(rcvd), W'(6));
      chk("bp_last_pop_cycle", W'(last_pop), W'(9));
      chk("bp_queue_empty", W'(exp_q.size()), W'(0));
      @(negedge clk) in_valid = 1'b0;
      #1 chk("bp_no_duplicate", W'(out_valid), W'(0));

      // reset while two beats are in flight
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; in_funct6 = F_VADD;
      in_a = a1; in_b = a1; in_vl = 3'd4; in_vm = 1'b1;
      @(negedge clk) in_a = v7;
      @(negedge clk) rst = 1'b1;
      @(negedge clk);
      chk("midrst_out_valid", W'(out_valid), W'(0));
      rst = 1'b0; in_valid = 1'b0;
      stale = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (out_valid) stale++;
      end
      chk("midrst_no_stale", W'(stale), W'(0));
      chk("midrst_in_ready", W'(in_ready), W'(1));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
